pin_capture: RTL and testbench
==============================

Name: pin_capture

Overview:
- Input-direction counterpart of the per-pin PWM generator: measures the waveform on one FPGA pin instead of driving it.
- Synchronises the pin and times each high phase and low phase in clk ticks (20 ns).
- Stores completed {high, low} pairs in a small FIFO that the host drains over the shared address/data register bus.
- One instance per pin, placed at a per-pin address window.

Parameters:
- POSITION, 0: base of this pin's local register window; local registers sit at POSITION+1 .. POSITION+6.
- FIFO_DEPTH, 8: number of {high, low} pairs buffered; power of two, 2..64.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- addr  input  21  register bus address.
- data_in  input  16  register bus write data.
- wr  input  1  write strobe, qualifies addr/data_in.
- rd  input  1  read strobe, qualifies addr.
- data_out  output  16  registered read data.
- pin_input  input  1  asynchronous pin level.
- busy  output  1  high in WAIT_RISE, HIGH or LOW.

Behaviour:
- Reset (reset=0, async):
  - all registers, counters and FIFO pointers cleared; state=IDLE.
  - data_out=0, busy=0; synchroniser flops=0.
- Register map (write when wr and addr match):
  - 0 GLOBAL_CMD: 16-bit register, shared address across pins.
  - P+1 CAPTURE_CYCLES: number of pairs to capture.
  - P+2 RUN_INF: nonzero = capture indefinitely.
  - P+3 LOCAL_CMD: bit0 abort; bit1 clear FIFO and status. Bits self-clear; they act only in the write cycle.
  - P+4 STATUS, read-only: [0] busy, [1] done, [2] fifo_empty, [3] fifo_full, [4] overflow (sticky), [11:5] fifo_count.
  - P+5 HIGH_TIME, read-only: high count of FIFO head; does not pop.
  - P+6 LOW_TIME, read-only: low count of FIFO head; pops when FIFO is non-empty.
- Reads:
  - data_out updates on the clock edge after rd with a mapped addr.
  - Unmapped addr or empty FIFO reads return 0.
  - data_out holds its value when rd=0.
- Synchroniser: 2 flops followed by a previous-value flop. rise = s & ~s_d; fall = ~s & s_d. Pin-to-edge latency is 3 cycles.
- State machine:
  - IDLE: clear cnt_high, cnt_low, pairs_done. Go to WAIT_RISE when GLOBAL_CMD==1 and (CAPTURE_CYCLES!=0 or RUN_INF!=0). done cleared on this transition.
  - WAIT_RISE: on rise, cnt_high=1 and go to HIGH. An initial partial high phase is never measured.
  - HIGH: cnt_high += 1 each cycle, saturating at 0xFFFF. On fall, cnt_low=1 and go to LOW.
  - LOW: cnt_low += 1, saturating at 0xFFFF. On rise:
    - push {cnt_high, cnt_low}; pairs_done += 1.
    - if RUN_INF==0 and pairs_done+1 == CAPTURE_CYCLES: set done, go to IDLE.
    - else cnt_high=1, go to HIGH.
  - Abort (LOCAL_CMD bit0) from any state: go to IDLE next cycle; FIFO contents kept; no partial pair pushed.
  - GLOBAL_CMD still ==1 on return to IDLE re-arms on the next cycle. The host clears GLOBAL_CMD to prevent re-arming.
- FIFO:
  - 32-bit entries, synchronous; count range 0..FIFO_DEPTH.
  - Push when full (without a same-cycle pop): pair dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed; count unchanged; no overflow.
  - Pop when empty: ignored; a same-cycle push still succeeds.
  - Clear (LOCAL_CMD bit1): pointers and count to 0, overflow=0, done=0. Clear wins over a same-cycle push/pop.
- Capture is unaffected by bus writes other than those listed above.

Decomposition:
- Shared package:
  - register offset constants (GLOBAL_CMD, local offsets 1..6), shared with pincontrol;
  - STATUS bit indices;
  - state encoding (one-hot, 4 states).
- One sub-module, pin_capture_fifo: parameterised sync FIFO with push/pop/clear, full/empty/count.

Test Plan:
- CAPTURE_CYCLES=2, GLOBAL_CMD=1, pin square wave 10 high / 5 low cycles -> FIFO holds 2 entries {10,5}; STATUS done=1, count=2; busy deasserts; HIGH_TIME read returns 10, LOW_TIME read returns 5 and count drops to 1.
- Pin held high at arm time, then low 4, high 7, low 3, high -> first pair {7,3}; the leading high phase is not recorded.
- RUN_INF=1, FIFO_DEPTH=8, 9 full periods with no reads -> count=8, overflow=1; the 9th pair is lost; entries are the first 8 in order.
- Pin high for 70000 cycles, then low 2, then high -> pair {0xFFFF, 2}.
- Abort written mid-LOW after 1 pair captured -> IDLE, count=1, done=0. LOCAL_CMD bit1 -> count=0, STATUS empty=1.
- reset pulsed low asynchronously mid-HIGH -> immediately state IDLE, data_out=0, busy=0, FIFO empty, all registers 0.

Source files
------------

// File: rtl/pin_capture_pkg.sv
// Shared definitions for the pin capture block: register offsets,
// STATUS bit positions, FSM encoding and the saturating counter helper.
package pin_capture_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;

  // Register map: GLOBAL_CMD is shared by all pins, the rest are
  // offsets from the per-pin window base.
  localparam logic [ADDR_W-1:0] GLOBAL_CMD_ADDR = '0;
  localparam int OFF_CAPTURE_CYCLES = 1;
  localparam int OFF_RUN_INF        = 2;
  localparam int OFF_LOCAL_CMD      = 3;
  localparam int OFF_STATUS         = 4;
  localparam int OFF_HIGH_TIME      = 5;
  localparam int OFF_LOW_TIME       = 6;

  // LOCAL_CMD bits (self-clearing, act only in the write cycle)
  localparam int LCMD_ABORT = 0;
  localparam int LCMD_CLEAR = 1;

  // STATUS bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_FULL      = 3;
  localparam int STAT_OVERFLOW  = 4;
  localparam int STAT_COUNT_LSB = 5;
  localparam int STAT_COUNT_MSB = 11;

  // One-hot capture state
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_WAIT_RISE = 4'b0010,
    ST_HIGH      = 4'b0100,
    ST_LOW       = 4'b1000
  } state_t;

  localparam logic [DATA_W-1:0] CNT_MAX = 16'hFFFF;

  // Phase counters stick at full scale rather than wrapping
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pin_capture_fifo.sv
// Small synchronous FIFO holding {high, low} phase pairs. A push into a
// full FIFO is dropped and latches a sticky overflow flag, unless a pop
// happens in the same cycle. Clear beats any same-cycle push or pop.
module pin_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts
  assign do_push  = push & (~full | do_pop);
  assign head     = mem[rd_ptr_reg];
  assign overflow = overflow_reg;
  assign count    = count_reg;

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer, occupancy and overflow bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && !do_push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pin_capture.sv
// Per-pin waveform capture: synchronises one pin, times each high and
// low phase in clk ticks and queues completed {high, low} pairs for the
// host to drain over the shared register bus.
module pin_capture
  import pin_capture_pkg::*;
#(
  parameter int POSITION   = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  input  logic              pin_input,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] A_CAPTURE_CYCLES = ADDR_W'(POSITION + OFF_CAPTURE_CYCLES);
  localparam logic [ADDR_W-1:0] A_RUN_INF        = ADDR_W'(POSITION + OFF_RUN_INF);
  localparam logic [ADDR_W-1:0] A_LOCAL_CMD      = ADDR_W'(POSITION + OFF_LOCAL_CMD);
  localparam logic [ADDR_W-1:0] A_STATUS         = ADDR_W'(POSITION + OFF_STATUS);
  localparam logic [ADDR_W-1:0] A_HIGH_TIME      = ADDR_W'(POSITION + OFF_HIGH_TIME);
  localparam logic [ADDR_W-1:0] A_LOW_TIME       = ADDR_W'(POSITION + OFF_LOW_TIME);

  // Host-visible configuration
  logic [DATA_W-1:0] global_cmd_reg;
  logic [DATA_W-1:0] capture_cycles_reg;
  logic [DATA_W-1:0] run_inf_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic [DATA_W-1:0] rd_data_next;
  logic [DATA_W-1:0] status_word;

  // Synchroniser and edge detect
  logic [1:0] sync_reg;
  logic       pin_d_reg;
  logic       pin_s;
  logic       rise;
  logic       fall;

  // Capture engine
  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [DATA_W-1:0] cnt_high_reg;
  logic [DATA_W-1:0] cnt_low_reg;
  logic [DATA_W-1:0] pairs_done_reg;
  logic              arm_ok;

  // Command decode
  logic abort_cmd;
  logic clear_cmd;

  // FIFO interface
  logic              fifo_push;
  logic              fifo_pop;
  logic [31:0]       fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_overflow;
  logic [CNT_W-1:0]  fifo_count;

  assign abort_cmd = wr && (addr == A_LOCAL_CMD) && data_in[LCMD_ABORT];
  assign clear_cmd = wr && (addr == A_LOCAL_CMD) && data_in[LCMD_CLEAR];

  assign pin_s = sync_reg[1];
  assign rise  = pin_s & ~pin_d_reg;
  assign fall  = ~pin_s & pin_d_reg;

  assign arm_ok = (global_cmd_reg == 16'd1) &&
                  ((capture_cycles_reg != '0) || (run_inf_reg != '0));

  // a pair completes on the rise that ends a low phase; abort suppresses it
  assign fifo_push = (state_reg == ST_LOW) && rise && !abort_cmd;
  assign fifo_pop  = rd && (addr == A_LOW_TIME);

  assign data_out = data_out_reg;
  assign busy     = busy_reg;

  // Writable registers; LOCAL_CMD has no storage, its bits are pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      global_cmd_reg     <= '0;
      capture_cycles_reg <= '0;
      run_inf_reg        <= '0;
    end else if (wr) begin
      if (addr == GLOBAL_CMD_ADDR)  global_cmd_reg     <= data_in;
      if (addr == A_CAPTURE_CYCLES) capture_cycles_reg <= data_in;
      if (addr == A_RUN_INF)        run_inf_reg        <= data_in;
    end
  end

  // Two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg  <= '0;
      pin_d_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], pin_input};
      pin_d_reg <= sync_reg[1];
    end
  end

  // Capture state machine with registered busy and done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      cnt_high_reg   <= '0;
      cnt_low_reg    <= '0;
      pairs_done_reg <= '0;
    end else begin
      if (abort_cmd) begin
        state_reg <= ST_IDLE;
        busy_reg  <= 1'b0;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            cnt_high_reg   <= '0;
            cnt_low_reg    <= '0;
            pairs_done_reg <= '0;
            if (arm_ok) begin
              state_reg <= ST_WAIT_RISE;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end
          end
          ST_WAIT_RISE: begin
            // a high phase already in progress at arm time is skipped
            if (rise) begin
              cnt_high_reg <= 16'd1;
              state_reg    <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              cnt_low_reg <= 16'd1;
              state_reg   <= ST_LOW;
            end else begin
              cnt_high_reg <= sat_inc(cnt_high_reg);
            end
          end
          ST_LOW: begin
            if (rise) begin
              pairs_done_reg <= pairs_done_reg + 16'd1;
              if ((run_inf_reg == '0) &&
                  (pairs_done_reg + 16'd1 == capture_cycles_reg)) begin
                done_reg  <= 1'b1;
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                cnt_high_reg <= 16'd1;
                state_reg    <= ST_HIGH;
              end
            end else begin
              cnt_low_reg <= sat_inc(cnt_low_reg);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
      // clearing status overrides a completion in the same cycle
      if (clear_cmd) begin
        done_reg <= 1'b0;
      end
    end
  end

  // STATUS word assembly
  always_comb begin
    status_word = '0;
    status_word[STAT_BUSY]     = busy_reg;
    status_word[STAT_DONE]     = done_reg;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_OVERFLOW] = fifo_overflow;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 7'(fifo_count);
  end

  // Read mux; unmapped addresses and an empty FIFO read as zero
  always_comb begin
    rd_data_next = '0;
    if (addr == GLOBAL_CMD_ADDR) begin
      rd_data_next = global_cmd_reg;
    end else if (addr == A_CAPTURE_CYCLES) begin
      rd_data_next = capture_cycles_reg;
    end else if (addr == A_RUN_INF) begin
      rd_data_next = run_inf_reg;
    end else if (addr == A_STATUS) begin
      rd_data_next = status_word;
    end else if (addr == A_HIGH_TIME) begin
      rd_data_next = fifo_empty ? '0 : fifo_head[31:16];
    end else if (addr == A_LOW_TIME) begin
      rd_data_next = fifo_empty ? '0 : fifo_head[15:0];
    end
  end

  // Registered read data, held while rd is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_reg <= '0;
    end else if (rd) begin
      data_out_reg <= rd_data_next;
    end
  end

  pin_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cnt_high_reg, cnt_low_reg}),
    .pop       (fifo_pop),
    .clear     (clear_cmd),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overflow  (fifo_overflow),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pin_capture.sv
// Randomised scoreboard bench for pin_capture: a queue-based model of the
// captured pairs and status drives expected read data; a monitor compares
// every register read as data_out presents it.
module tb_pin_capture;

  localparam int DEPTH = 8;
  localparam int POS   = 32;
  localparam logic [20:0] A_GLOBAL = 21'd0;
  localparam logic [20:0] A_CC     = 21'(POS + 1);
  localparam logic [20:0] A_RI     = 21'(POS + 2);
  localparam logic [20:0] A_LCMD   = 21'(POS + 3);
  localparam logic [20:0] A_STAT   = 21'(POS + 4);
  localparam logic [20:0] A_HIGH   = 21'(POS + 5);
  localparam logic [20:0] A_LOW    = 21'(POS + 6);

  logic        clk;
  logic        reset;
  logic [20:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        pin_input;
  logic        busy;

  pin_capture #(.POSITION(POS), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .data_in   (data_in),
    .wr        (wr),
    .rd        (rd),
    .data_out  (data_out),
    .pin_input (pin_input),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_fifo[$];
  bit          m_ovf;
  bit          m_done;
  bit          m_busy;
  logic [15:0] m_global;
  logic [15:0] m_cc;
  logic [15:0] m_ri;

  int hs[16];
  int ls[16];

  typedef struct packed {
    logic [20:0] a;
    logic [15:0] exp;
  } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t mon_e;

  int   checks;
  int   errors;
  logic rd_q;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[0]    = m_busy;
    s[1]    = m_done;
    s[2]    = (m_fifo.size() == 0);
    s[3]    = (m_fifo.size() == DEPTH);
    s[4]    = m_ovf;
    s[11:5] = 7'(m_fifo.size());
    return s;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_ovf = 0; m_done = 0; m_busy = 0;
    m_global = '0; m_cc = '0; m_ri = '0;
  endtask

  // Pairs formed from complete high-then-low phases after arming
  task automatic model_pairs(input int n);
    int got;
    got = 0;
    for (int i = 0; i < n; i++) begin
      if (m_ri == 0 && got == int'(m_cc)) break;
      if (m_fifo.size() < DEPTH) m_fifo.push_back({16'(sat16(hs[i])), 16'(sat16(ls[i]))});
      else m_ovf = 1;
      got++;
    end
    if (m_ri == 0 && got == int'(m_cc)) begin
      m_done = 1;
      m_busy = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // ---------------- bus tasks (start and end on a negedge) ----------------
  task automatic bus_write(input logic [20:0] a, input logic [15:0] d);
    wr = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    wr = 1'b0;
    $display("wr   addr=%0d data=%0h", a, d);
    if (a == A_GLOBAL) m_global = d;
    if (a == A_CC)     m_cc = d;
    if (a == A_RI)     m_ri = d;
    if (a == A_LCMD) begin
      if (d[0]) m_busy = 0;
      if (d[1]) begin m_fifo.delete(); m_ovf = 0; m_done = 0; end
    end
  endtask

  task automatic bus_read(input logic [20:0] a);
    rd_exp_t e;
    e.a = a;
    e.exp = '0;
    if (a == A_GLOBAL)    e.exp = m_global;
    else if (a == A_CC)   e.exp = m_cc;
    else if (a == A_RI)   e.exp = m_ri;
    else if (a == A_STAT) e.exp = m_status();
    else if (a == A_HIGH) e.exp = (m_fifo.size() != 0) ? m_fifo[0][31:16] : 16'd0;
    else if (a == A_LOW)  e.exp = (m_fifo.size() != 0) ? m_fifo.pop_front() & 32'hFFFF : 16'd0;
    sb.push_back(e);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic arm(input bit keep);
    bus_write(A_GLOBAL, 16'd1);
    if (m_cc != 0 || m_ri != 0) begin m_busy = 1; m_done = 0; end
    if (!keep) bus_write(A_GLOBAL, 16'd0);
  endtask

  task automatic drive(input logic lv, input int cyc);
    pin_input = lv;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic run_wave(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hs[i]);
      drive(1'b0, ls[i]);
    end
    drive(1'b1, 8);
    model_pairs(n);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("busy_idle", 32'(busy), 32'(0));
  endtask

  task automatic drain_and_clear();
    int n;
    n = m_fifo.size();
    for (int i = 0; i < n; i++) begin
      bus_read(A_HIGH);
      bus_read(A_LOW);
    end
    bus_read(A_STAT);
    bus_write(A_LCMD, 16'h0002);
    bus_read(A_STAT);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) rd_q <= rd;

  always @(negedge clk) begin
    if (rd_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", data_out);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("rd@%0d", mon_e.a), 32'(data_out), 32'(mon_e.exp));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    checks = 0; errors = 0; rd_q = 1'b0;
    reset = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0; pin_input = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_data_out", 32'(data_out), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    bus_read(A_STAT);
    bus_read(21'd1);

    // 1: two pairs of 10 high / 5 low; a third period is ignored
    bus_write(A_CC, 16'd2);
    drive(1'b0, 5);
    arm(0);
    for (int i = 0; i < 3; i++) begin hs[i] = 10; ls[i] = 5; end
    run_wave(3);
    wait_idle(50);
    bus_read(A_STAT);
    bus_read(A_HIGH);
    bus_read(A_LOW);
    bus_read(A_STAT);
    drain_and_clear();

    // 2: pin already high at arm time; leading high not recorded
    bus_write(A_CC, 16'd1);
    drive(1'b1, 5);
    arm(0);
    drive(1'b1, 5);
    drive(1'b0, 4);
    hs[0] = 7; ls[0] = 3;
    run_wave(1);
    wait_idle(50);
    bus_read(A_STAT);
    drain_and_clear();

    // 3: randomised bounded captures
    for (int it = 0; it < 3; it++) begin
      bus_write(A_CC, 16'($urandom_range(1, 4)));
      n = int'(m_cc) + int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        hs[i] = int'($urandom_range(1, 25));
        ls[i] = int'($urandom_range(1, 25));
      end
      drive(1'b0, 5);
      arm(0);
      run_wave(n);
      wait_idle(50);
      bus_read(A_STAT);
      drain_and_clear();
    end

    // 4: run indefinitely, 9 periods into an 8-deep FIFO
    bus_write(A_CC, 16'd0);
    bus_write(A_RI, 16'd1);
    for (int i = 0; i < 9; i++) begin
      hs[i] = int'($urandom_range(1, 20));
      ls[i] = int'($urandom_range(1, 20));
    end
    drive(1'b0, 5);
    arm(0);
    run_wave(9);
    chk("busy_run_inf", 32'(busy), 32'(m_busy));
    bus_read(A_STAT);
    bus_write(A_LCMD, 16'h0001);
    @(negedge clk);
    bus_read(A_STAT);
    drain_and_clear();
    bus_read(A_HIGH);
    bus_read(A_LOW);
    bus_write(A_RI, 16'd0);

    // 5: high phase saturates
    bus_write(A_CC, 16'd1);
    drive(1'b0, 5);
    arm(0);
    hs[0] = 70000; ls[0] = 2;
    run_wave(1);
    wait_idle(50);
    drain_and_clear();

    // 6: abort mid-LOW after one pair
    bus_write(A_CC, 16'd5);
    drive(1'b0, 5);
    arm(0);
    hs[0] = 6; ls[0] = 4;
    run_wave(1);
    drive(1'b0, 4);
    bus_write(A_LCMD, 16'h0001);
    drive(1'b0, 3);
    drive(1'b1, 6);
    chk("busy_after_abort", 32'(busy), 32'(0));
    bus_read(A_STAT);
    bus_write(A_LCMD, 16'h0002);
    bus_read(A_STAT);
    bus_read(A_LOW);

    // 7: asynchronous reset mid-HIGH
    bus_write(A_CC, 16'd3);
    drive(1'b0, 5);
    arm(1);
    hs[0] = 9; ls[0] = 6;
    run_wave(1);
    bus_read(A_CC);
    chk("busy_before_reset", 32'(busy), 32'(1));
    #3 reset = 1'b0;
    #1;
    chk("async_reset_data_out", 32'(data_out), 32'(0));
    chk("async_reset_busy", 32'(busy), 32'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(A_STAT);
    bus_read(A_GLOBAL);
    bus_read(A_CC);
    bus_read(A_RI);
    bus_read(A_HIGH);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
